// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus: request/address from the fetch stage, ready/data back.
interface if_stage_if;
    localparam int unsigned XLEN = 32;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            rdy;
    logic [XLEN-1:0] rdata;

    modport master (output req, output addr, input rdy, input rdata);
    modport slave  (input req, input addr, output rdy, output rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over the imem handshake and loads
// the IF_ID buffer, handling stalls, branch redirects and interrupt-entry bubbles.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR = 32'h0000_0010,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    if_stage_if.master  imem,
    input  logic        stall,
    input  logic        branch_sel,
    input  logic [31:0] branch_pc,
    input  logic        int_req,
    input  logic        returni,
    output logic        int_active,
    output logic [31:0] pc_plus_4,
    output logic [31:0] instr,
    output logic        interrupt
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] target, target_n;
    logic [XLEN-1:0] skid, skid_n;
    logic [XLEN-1:0] pc_plus_4_n, instr_n;
    logic            interrupt_n, int_active_n, req_q, req_n;
    logic            fire, pending, take_int;

    // pc always holds the address on the bus, including the stale one in DISCARD
    assign imem.req  = req_q;
    assign imem.addr = pc;

    assign fire     = req_q & imem.rdy;
    assign pending  = req_q & ~imem.rdy;
    assign take_int = (state == FETCH) & int_req & ~int_active & ~branch_sel & ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            target     <= RESET_PC;
            skid       <= NOP_INSTR;
            pc_plus_4  <= '0;
            instr      <= NOP_INSTR;
            interrupt  <= 1'b0;
            int_active <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            target     <= target_n;
            skid       <= skid_n;
            pc_plus_4  <= pc_plus_4_n;
            instr      <= instr_n;
            interrupt  <= interrupt_n;
            int_active <= int_active_n;
            req_q      <= req_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        target_n     = target;
        skid_n       = skid;
        pc_plus_4_n  = pc_plus_4;
        instr_n      = instr;
        interrupt_n  = interrupt;
        int_active_n = int_active & ~returni;

        if (branch_sel) begin
            // flush wins over stall; an in-flight request must drain first
            pc_plus_4_n = '0;
            instr_n     = NOP_INSTR;
            interrupt_n = 1'b0;
            target_n    = branch_pc;
            if (pending) begin
                state_n = DISCARD;
            end else begin
                pc_n    = branch_pc;
                state_n = FETCH;
            end
        end else begin
            unique case (state)
                FETCH: begin
                    if (stall) begin
                        if (fire) begin
                            skid_n  = imem.rdata;
                            state_n = HOLD;
                        end
                    end else if (take_int) begin
                        pc_plus_4_n  = pc;
                        instr_n      = NOP_INSTR;
                        interrupt_n  = 1'b1;
                        int_active_n = 1'b1;
                        target_n     = INT_VECTOR;
                        if (pending) state_n = DISCARD;
                        else         pc_n    = INT_VECTOR;
                    end else if (fire) begin
                        pc_plus_4_n = pc + XLEN'(4);
                        instr_n     = imem.rdata;
                        interrupt_n = 1'b0;
                        pc_n        = pc + XLEN'(4);
                    end else begin
                        instr_n     = NOP_INSTR;
                        interrupt_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc_plus_4_n = pc + XLEN'(4);
                        instr_n     = skid;
                        interrupt_n = 1'b0;
                        pc_n        = pc + XLEN'(4);
                        state_n     = FETCH;
                    end
                end
                DISCARD: begin
                    if (!stall) begin
                        instr_n     = NOP_INSTR;
                        interrupt_n = 1'b0;
                    end
                    if (fire) begin
                        pc_n    = target;
                        state_n = FETCH;
                    end
                end
                default: state_n = FETCH;
            endcase
        end

        req_n = (state_n != HOLD);
    end
endmodule
